// File: rtl/npu_arith_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : npu_arith_core
// Description : PE arithmetic core. Performs a 9-lane signed MAC over several beats,
//               adds bias, requantises with saturation, applies optional ReLU and
//               optional 4:1 max-pool.
// Revision    : 1.0 - initial release
// ============================================================================
module npu_arith_core #(
    parameter int LANES = 9,
    parameter int DW    = 8,
    parameter int ACCW  = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [LANES*DW-1:0] in,
    input  logic [LANES*DW-1:0] weight,
    input  logic [15:0]         bias,
    input  logic [1:0]          bound_level,
    input  logic [2:0]          step,
    input  logic                en,
    input  logic                en_relu,
    input  logic                en_mp,
    output logic [DW-1:0]       out,
    output logic                out_en
);
    localparam logic signed [ACCW-1:0] c_qmax = ACCW'((2**(DW-1)) - 1);
    localparam logic signed [ACCW-1:0] c_qmin = ACCW'(-(2**(DW-1)));

    logic [LANES*DW-1:0]     r_in;
    logic [LANES*DW-1:0]     r_wt;
    logic                    r_v;
    logic signed [ACCW-1:0]  r_acc;
    logic [2:0]              r_cnt;
    logic signed [DW-1:0]    r_q;
    logic                    r_q_v;
    logic [1:0]              r_pool_cnt;
    logic signed [DW-1:0]    r_max;

    logic signed [2*DW-1:0]  w_prod [LANES];
    logic signed [ACCW-1:0]  w_sum;
    logic signed [ACCW-1:0]  w_acc_next;
    logic signed [ACCW-1:0]  w_res;
    logic signed [ACCW-1:0]  w_shr;
    logic signed [DW-1:0]    w_q;
    logic                    w_last;
    logic signed [DW-1:0]    w_max_next;

    // Lane 0 sits in the most significant byte of the packed vectors.
    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            assign w_prod[g] = (2*DW)'($signed(r_in[(LANES-1-g)*DW +: DW]))
                             * (2*DW)'($signed(r_wt[(LANES-1-g)*DW +: DW]));
        end
    endgenerate

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_sum = w_sum + ACCW'(w_prod[i]);
        end
        w_acc_next = r_acc + w_sum;
        w_res      = w_acc_next + ACCW'($signed(bias));
        w_shr      = w_res >>> {bound_level, 2'b00};
        if (w_shr > c_qmax) begin
            w_q = c_qmax[DW-1:0];
        end else if (w_shr < c_qmin) begin
            w_q = c_qmin[DW-1:0];
        end else begin
            w_q = w_shr[DW-1:0];
        end
        if (en_relu && w_q[DW-1]) begin
            w_q = '0;
        end
    end

    assign w_last     = (r_cnt == step);
    // First result of a pool window always loads the running max.
    assign w_max_next = ((r_pool_cnt == 2'd0) || (r_q > r_max)) ? r_q : r_max;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in       <= '0;
            r_wt       <= '0;
            r_v        <= 1'b0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_q        <= '0;
            r_q_v      <= 1'b0;
            r_pool_cnt <= '0;
            r_max      <= '0;
            out        <= '0;
            out_en     <= 1'b0;
        end else begin
            r_v    <= en;
            r_q_v  <= 1'b0;
            out_en <= 1'b0;
            if (en) begin
                r_in <= in;
                r_wt <= weight;
            end
            if (r_v) begin
                if (w_last) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                    r_q   <= w_q;
                    r_q_v <= 1'b1;
                end else begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 3'd1;
                end
            end
            if (r_q_v) begin
                if (!en_mp) begin
                    out    <= r_q;
                    out_en <= 1'b1;
                end else if (r_pool_cnt == 2'd3) begin
                    out        <= w_max_next;
                    out_en     <= 1'b1;
                    r_pool_cnt <= '0;
                    r_max      <= '0;
                end else begin
                    r_max      <= w_max_next;
                    r_pool_cnt <= r_pool_cnt + 2'd1;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_npu_arith_core.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for npu_arith_core: hand-computed single-group vectors plus
// cycle-accurate scoreboarded streams (pooling, multi-beat, gaps, reset).
module tb_npu_arith_core;
    logic        clk = 1'b0;
    logic        reset;
    logic [71:0] in_v, w_v;
    logic [15:0] bias;
    logic [1:0]  bound_level;
    logic [2:0]  step;
    logic        en, en_relu, en_mp;
    logic [7:0]  out;
    logic        out_en;

    always #5 clk = ~clk;

    npu_arith_core dut (
        .clk(clk), .reset(reset), .in(in_v), .weight(w_v), .bias(bias),
        .bound_level(bound_level), .step(step), .en(en), .en_relu(en_relu),
        .en_mp(en_mp), .out(out), .out_en(out_en)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       exp_v [4096];
    logic [7:0] exp_o [4096];
    bit         mon_on = 1'b0;
    int         n_out = 0;
    int m_acc, m_cnt, m_pool, m_max;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at cyc %0d: actual=%0h required=%0h", nm, cyc, act, req);
        end
    endtask

    // Expected-output timeline indexed by posedge count.
    always @(negedge clk) begin
        if (mon_on) begin
            chk("out_en_timing", 32'(out_en), 32'(exp_v[cyc]));
            if (exp_v[cyc]) chk("out_value", 32'(out), 32'(exp_o[cyc]));
            if (out_en) n_out++;
        end
    end

    function automatic logic [71:0] lane(input int idx, input int v);
        logic [71:0] r;
        logic [7:0]  b;
        r = '0;
        b = v[7:0];
        r[71-8*idx -: 8] = b;
        return r;
    endfunction

    function automatic logic [71:0] splat(input int v);
        logic [7:0] b;
        b = v[7:0];
        return {9{b}};
    endfunction

    function automatic int dot(input logic [71:0] a, input logic [71:0] b);
        int s, x, y;
        s = 0;
        for (int i = 0; i < 9; i++) begin
            x = $signed(a[71-8*i -: 8]);
            y = $signed(b[71-8*i -: 8]);
            s += x * y;
        end
        return s;
    endfunction

    function automatic int requant(input int r);
        int s;
        s = r >>> (4 * int'(bound_level));
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        if (en_relu && s < 0) s = 0;
        return s;
    endfunction

    function automatic logic [71:0] gen(input int k, input int pat, input bit is_w);
        logic [71:0] r;
        r = '0;
        if (pat == 0) begin
            r = is_w ? splat(1) : splat((k % 7) - 3);
        end else begin
            for (int i = 0; i < 9; i++)
                r |= lane(i, is_w ? (((k + i) % 5) - 2) : (((k * 7 + i * 3) % 11) - 5));
        end
        return r;
    endfunction

    task automatic sched(input int v);
        int t;
        t = cyc + 3;
        exp_v[t] = 1'b1;
        exp_o[t] = v[7:0];
    endtask

    // Drive one cycle (called just after a negedge) and update the reference model.
    task automatic drive(input bit e, input logic [71:0] a, input logic [71:0] b);
        int q;
        en = e; in_v = a; w_v = b;
        if (e) begin
            m_acc += dot(a, b);
            if (m_cnt == int'(step)) begin
                q = requant(m_acc + int'($signed(bias)));
                m_acc = 0; m_cnt = 0;
                if (!en_mp) sched(q);
                else begin
                    if (m_pool == 0 || q > m_max) m_max = q;
                    if (m_pool == 3) begin sched(m_max); m_pool = 0; end
                    else m_pool++;
                end
            end else m_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic cfg_reset(input int st, input int bl, input logic [15:0] bi,
                             input bit relu, input bit mp);
        mon_on = 1'b0;
        reset = 1'b0;
        en = 1'b0;
        #1;
        chk("reset_out", 32'(out), 32'h0);
        chk("reset_out_en", 32'(out_en), 32'h0);
        step = st[2:0]; bound_level = bl[1:0]; bias = bi; en_relu = relu; en_mp = mp;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        m_acc = 0; m_cnt = 0; m_pool = 0; m_max = 0;
        for (int i = 0; i < 4096; i++) exp_v[i] = 1'b0;
    endtask

    task automatic run_stream(input int st, input int bl, input logic [15:0] bi, input bit relu,
                              input bit mp, input int nbeats, input int pat, input bit gaps,
                              input int exp_cnt, input string nm);
        cfg_reset(st, bl, bi, relu, mp);
        n_out = 0;
        mon_on = 1'b1;
        for (int k = 0; k < nbeats; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                for (int g = 0; g < int'($urandom_range(1, 3)); g++) drive(1'b0, '0, '0);
            end
            drive(1'b1, gen(k, pat, 1'b0), gen(k, pat, 1'b1));
        end
        for (int k = 0; k < 4; k++) drive(1'b0, '0, '0);
        mon_on = 1'b0;
        chk(nm, 32'(n_out), 32'(exp_cnt));
    endtask

    typedef struct {
        logic [71:0] a;
        logic [71:0] b;
        logic [15:0] bi;
        int          bl;
        bit          relu;
        logic [7:0]  exp;
        string       nm;
    } vec_t;

    vec_t tv [12];

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b1; en = 1'b0; in_v = '0; w_v = '0; bias = '0;
        bound_level = '0; step = '0; en_relu = 1'b0; en_mp = 1'b0;
        for (int i = 0; i < 4096; i++) begin exp_v[i] = 1'b0; exp_o[i] = '0; end

        tv[0]  = '{splat(1), splat(1), 16'h0000, 0, 1'b1, 8'h09, "ones"};
        tv[1]  = '{splat(1), splat(-1), 16'h0000, 0, 1'b1, 8'h00, "neg_relu"};
        tv[2]  = '{splat(1), splat(-1), 16'h0000, 0, 1'b0, 8'hF7, "neg_norelu"};
        tv[3]  = '{lane(0, 64), lane(0, 20), 16'h0000, 2, 1'b0, 8'h05, "sum_0500"};
        tv[4]  = '{lane(0, 127) | lane(1, 127) | lane(2, 127),
                   lane(0, 127) | lane(1, 127) | lane(2, 2), 16'h0000, 2, 1'b0, 8'h7F, "sum_7F00"};
        tv[5]  = '{lane(0, -128) | lane(1, -128) | lane(2, -128),
                   lane(0, 127) | lane(1, 127) | lane(2, 34), 16'h0000, 2, 1'b0, 8'h80, "sat_neg"};
        tv[6]  = '{72'h0, 72'h0, 16'h7FFF, 0, 1'b0, 8'h7F, "sat_pos_bias"};
        tv[7]  = '{splat(16), splat(1), 16'hFFF0, 1, 1'b0, 8'h08, "shift4_bias"};
        tv[8]  = '{72'h0, 72'h0, 16'h7000, 3, 1'b0, 8'h07, "shift12"};
        tv[9]  = '{72'h0, 72'h0, 16'hFFFB, 0, 1'b0, 8'hFB, "neg_bias"};
        tv[10] = '{lane(0,1)|lane(1,2)|lane(2,3)|lane(3,4)|lane(4,5)|lane(5,6)|lane(6,7)|lane(7,8)|lane(8,9),
                   lane(0,-4)|lane(1,-3)|lane(2,-2)|lane(3,-1)|lane(4,0)|lane(5,1)|lane(6,2)|lane(7,3)|lane(8,4),
                   16'h0003, 0, 1'b1, 8'h3F, "mixed_lanes"};
        tv[11] = '{lane(4, -128), lane(4, -128), 16'h0000, 2, 1'b1, 8'h40, "minmin"};

        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            cfg_reset(0, tv[i].bl, tv[i].bi, tv[i].relu, 1'b0);
            mon_on = 1'b1;
            drive(1'b1, tv[i].a, tv[i].b);
            drive(1'b0, '0, '0);
            drive(1'b0, '0, '0);
            chk({tv[i].nm, "_valid"}, 32'(out_en), 32'h1);
            chk(tv[i].nm, 32'(out), 32'(tv[i].exp));
            mon_on = 1'b0;
        end

        run_stream(0, 0, 16'h0000, 1'b1, 1'b0, 64, 0, 1'b0, 64, "count_step0");
        run_stream(0, 0, 16'h0000, 1'b1, 1'b1, 64, 0, 1'b0, 16, "count_step0_mp");
        run_stream(1, 0, 16'h0000, 1'b1, 1'b1, 64, 1, 1'b0, 8,  "count_step1_mp");
        run_stream(3, 0, 16'h0005, 1'b0, 1'b0, 64, 1, 1'b0, 16, "count_step3");
        run_stream(3, 0, 16'h0000, 1'b1, 1'b1, 64, 1, 1'b1, 4,  "count_gaps_mp");

        // Reset in the middle of a group must discard the partial sum.
        cfg_reset(3, 0, 16'h0000, 1'b0, 1'b0);
        mon_on = 1'b1;
        for (int k = 0; k < 4; k++) drive(1'b1, splat(1), splat(1));
        for (int k = 0; k < 3; k++) drive(1'b0, '0, '0);
        chk("pre_reset_out", 32'(out), 32'h24);
        drive(1'b1, splat(50), splat(50));
        drive(1'b1, splat(50), splat(50));
        cfg_reset(3, 0, 16'h0000, 1'b0, 1'b0);
        mon_on = 1'b1;
        for (int k = 0; k < 4; k++) drive(1'b1, splat(2), splat(1));
        drive(1'b0, '0, '0);
        drive(1'b0, '0, '0);
        chk("post_reset_valid", 32'(out_en), 32'h1);
        chk("post_reset_out", 32'(out), 32'h48);
        for (int k = 0; k < 3; k++) drive(1'b0, '0, '0);
        chk("hold_out", 32'(out), 32'h48);
        chk("hold_out_en", 32'(out_en), 32'h0);
        mon_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
